// File: rtl/mult_pkg.sv
// Shared widths, signed-mode correction constant and adder cells for the SIMD multiplier lanes.
package mult_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned RES_W = 4;

  // Two's-complement correction for a 2x2 product: -4 mod 16, added only in signed mode.
  localparam logic [RES_W-1:0] SIGNED_CORR = 4'b1100;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/two_bit_mult_core.sv
// Combinational 2x2 partial-product multiplier with Baugh-Wooley signed correction.
module two_bit_mult_core
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             signed_mode,
  output logic [RES_W-1:0] product
);

  logic pp00, pp01, pp10, pp11;
  logic x_term, y_term;
  logic corr2, corr3;
  logic [1:0] ha1, fa2;

  always_comb begin
    pp00 = a[0] & b[0];
    pp01 = a[0] & b[1];
    pp10 = a[1] & b[0];
    pp11 = a[1] & b[1];

    // Cross terms carry negative weight in signed mode, so they are inverted.
    x_term = pp10 ^ signed_mode;
    y_term = pp01 ^ signed_mode;
    corr2  = signed_mode & SIGNED_CORR[2];
    corr3  = signed_mode & SIGNED_CORR[3];

    ha1 = half_add(x_term, y_term);
    fa2 = full_add(pp11, ha1[1], corr2);

    // Carry out of bit 3 is dropped: the result is modulo 16.
    product = {fa2[1] ^ corr3, fa2[0], ha1[0], pp00};
  end

endmodule

// File: rtl/two_bit_multiplier.sv
// 2x2 multiplier lane: combinational core plus an optional one-cycle registered output stage.
module two_bit_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned OUT_REG = 1
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             signed_mode,
  input  logic             in_valid,
  output logic [RES_W-1:0] result,
  output logic             out_valid
);

  logic [RES_W-1:0] product;

  two_bit_mult_core u_core (
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .product     (product)
  );

  generate
    if (OUT_REG != 0) begin : g_reg
      // Result holds across idle cycles; reset drops any product in flight.
      always_ff @(posedge CLK) begin
        if (rst) begin
          result    <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) begin
            result <= product;
          end
        end
      end
    end else begin : g_comb
      assign result    = product;
      assign out_valid = in_valid & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_two_bit_multiplier.sv
// Self-checking bench for two_bit_multiplier in both registered and combinational builds.
module tb_two_bit_multiplier;

  logic       CLK = 1'b0;
  logic       rst;
  logic [1:0] a, b;
  logic       signed_mode;
  logic       in_valid;
  logic [3:0] result_r, result_c;
  logic       out_valid_r, out_valid_c;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  two_bit_multiplier #(.OUT_REG(1)) dut_reg (
    .CLK(CLK), .rst(rst), .a(a), .b(b), .signed_mode(signed_mode),
    .in_valid(in_valid), .result(result_r), .out_valid(out_valid_r)
  );

  two_bit_multiplier #(.OUT_REG(0)) dut_comb (
    .CLK(CLK), .rst(rst), .a(a), .b(b), .signed_mode(signed_mode),
    .in_valid(in_valid), .result(result_c), .out_valid(out_valid_c)
  );

  // Reference: interpret operands as integers and take the low 4 bits of the product.
  function automatic logic [3:0] ref_prod(input logic [1:0] ra, input logic [1:0] rb,
                                          input logic sm);
    int va, vb;
    va = int'(ra);
    vb = int'(rb);
    if (sm && ra[1]) va = va - 4;
    if (sm && rb[1]) vb = vb - 4;
    return 4'(va * vb);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] da, input logic [1:0] db, input logic sm,
                       input logic v);
    a = da; b = db; signed_mode = sm; in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b11, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (result_r !== 4'b0000 || out_valid_r !== 1'b0) begin
        failures++;
        $display("FAIL reset_cycle%0d: result=%b out_valid=%b, want 0000/0", i, result_r, out_valid_r);
      end
    end
    checks++;
    if (out_valid_c !== 1'b0 || result_c !== 4'b1001) begin
      failures++;
      $display("FAIL reset_comb: result=%b out_valid=%b, want 1001/0", result_c, out_valid_c);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (result_r !== 4'b1001 || out_valid_r !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: result=%b out_valid=%b, want 1001/1", result_r, out_valid_r);
    end
  endtask

  task automatic test_unsigned_directed();
    logic [1:0] va [3] = '{2'b11, 2'b01, 2'b10};
    logic [1:0] vb [3] = '{2'b11, 2'b01, 2'b01};
    logic [3:0] ve [3] = '{4'b1001, 4'b0001, 4'b0010};
    for (int i = 0; i < 3; i++) begin
      drive(va[i], vb[i], 1'b0, 1'b1);
      tick();
      checks++;
      if (result_r !== ve[i] || out_valid_r !== 1'b1) begin
        failures++;
        $display("FAIL unsigned_directed%0d: result=%b out_valid=%b, want %b/1", i, result_r, out_valid_r, ve[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] exp;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        drive(2'(i >> 2), 2'(i), 1'(m), 1'b1);
        exp = ref_prod(2'(i >> 2), 2'(i), 1'(m));
        #1;
        checks++;
        if (result_c !== exp) begin
          failures++;
          $display("FAIL exh_comb m%0d a=%b b=%b: got %b want %b", m, a, b, result_c, exp);
        end
        tick();
        checks++;
        if (result_r !== exp || out_valid_r !== 1'b1) begin
          failures++;
          $display("FAIL exh_reg m%0d i%0d: result=%b out_valid=%b, want %b/1", m, i, result_r, out_valid_r, exp);
        end
      end
    end
  endtask

  task automatic test_signed_corners();
    logic [1:0] va [4] = '{2'b10, 2'b11, 2'b10, 2'b10};
    logic [1:0] vb [4] = '{2'b10, 2'b11, 2'b01, 2'b11};
    logic [3:0] ve [4] = '{4'b0100, 4'b0001, 4'b1110, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 1'b1, 1'b1);
      tick();
      checks++;
      if (result_r !== ve[i]) begin
        failures++;
        $display("FAIL signed_corner%0d: result=%b, want %b", i, result_r, ve[i]);
      end
    end
  endtask

  task automatic test_hold();
    drive(2'b11, 2'b10, 1'b0, 1'b1);
    tick();
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (result_r !== 4'b0110 || out_valid_r !== 1'b0) begin
        failures++;
        $display("FAIL hold%0d: result=%b out_valid=%b, want 0110/0", i, result_r, out_valid_r);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(2'b10, 2'b11, 1'b0, 1'b1);
    tick();
    checks++;
    if (result_r !== 4'b0110) begin
      failures++;
      $display("FAIL midstream_pre: result=%b, want 0110", result_r);
    end
    rst = 1'b1;
    drive(2'b11, 2'b11, 1'b0, 1'b1);
    tick();
    checks++;
    if (result_r !== 4'b0000 || out_valid_r !== 1'b0) begin
      failures++;
      $display("FAIL midstream_rst: result=%b out_valid=%b, want 0000/0", result_r, out_valid_r);
    end
    rst = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    tick();
    checks++;
    if (result_r !== 4'b0000 || out_valid_r !== 1'b0) begin
      failures++;
      $display("FAIL midstream_after: result=%b out_valid=%b, want 0000/0", result_r, out_valid_r);
    end
  endtask

  task automatic test_comb_build();
    drive(2'b11, 2'b11, 1'b0, 1'b1);
    #1;
    checks++;
    if (result_c !== 4'b1001 || out_valid_c !== 1'b1) begin
      failures++;
      $display("FAIL comb_build: result=%b out_valid=%b, want 1001/1", result_c, out_valid_c);
    end
  endtask

  task automatic test_random();
    logic [3:0] held;
    logic       exp_v;
    logic [1:0] ra, rb;
    logic       rs, rv;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held = 4'b0000;
    for (int i = 0; i < 200; i++) begin
      ra = 2'($urandom);
      rb = 2'($urandom);
      rs = 1'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      drive(ra, rb, rs, rv);
      if (rv) held = ref_prod(ra, rb, rs);
      exp_v = rv;
      tick();
      checks++;
      if (result_r !== held || out_valid_r !== exp_v) begin
        failures++;
        $display("FAIL random%0d a=%b b=%b sm=%b v=%b: result=%b out_valid=%b, want %b/%b",
                 i, ra, rb, rs, rv, result_r, out_valid_r, held, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    test_reset();
    test_unsigned_directed();
    test_exhaustive();
    test_signed_corners();
    test_hold();
    test_reset_midstream();
    test_comb_build();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/two_bit_multiplier.md
Name: two_bit_multiplier

Overview:
Multiplies two 2-bit operands and produces a 4-bit product. This is the smallest lane primitive of the SIMD multiplier family; wider SIMD multipliers tile it. The block has a combinational partial-product core and an optional registered output stage with a valid flag. An optional signed (two's-complement) mode is provided.

Parameters:
OUT_REG, 1, 1 = registered output with 1-cycle latency; 0 = purely combinational path (CLK/rst unused except for out_valid pass-through).

Ports:
CLK  input  1  single clock, rising-edge
rst  input  1  synchronous reset, active-high
a  input  2  operand A
b  input  2  operand B
signed_mode  input  1  0 = unsigned operands; 1 = two's-complement operands
in_valid  input  1  operands valid this cycle
result  output  4  product
out_valid  output  1  result valid

Behaviour:
- Unsigned mode: result = a*b, range 0..9. Exhaustive 16-entry truth table must hold; no overflow is possible.
- Signed mode: a and b are interpreted in -2..1. Result is the 4-bit two's-complement product, range -2..4, so it always fits.
  - 10*10 -> 0100 (+4)
  - 11*11 -> 0001
  - 10*01 -> 1110
  - 10*11 -> 0010
- Core structure: 4 AND partial products (a[i]&b[j]) summed with half/full adders.
  - Signed mode uses Baugh-Wooley correction: invert the MSB cross terms and add constant corrections, sign-extended into the 4-bit result.
  - No behavioural '*' operator in the core.
- OUT_REG=1:
  - On each rising CLK with rst=1: result<=0, out_valid<=0.
  - Otherwise out_valid<=in_valid.
  - If in_valid=1, result<=product(a,b,signed_mode). If in_valid=0, result holds its previous value.
  - Latency is exactly 1 cycle. Back-to-back in_valid every cycle gives throughput of 1 product per cycle.
  - Reset asserted in the same cycle as in_valid: reset wins, and the input is dropped.
- OUT_REG=0:
  - result = product(a,b,signed_mode) combinationally at all times, independent of in_valid and rst.
  - out_valid = in_valid & ~rst.
- X/undriven operands: no requirement; the bench must drive known values.
- signed_mode is sampled together with the operands. It may change every cycle without affecting results already registered.

Decomposition:
- Shared package mult_pkg:
  - OP_W=2, RES_W=4.
  - Constants for the signed-mode correction bits.
- One sub-module, two_bit_mult_core: purely combinational.
  - Inputs: a, b, signed_mode. Output: 4-bit product.
  - Contains the AND array, Baugh-Wooley correction, half/full adders.
- Top two_bit_multiplier: core plus the OUT_REG-controlled register/valid stage.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, a=11, b=11 -> result=0000, out_valid=0. After release, the next valid input appears 1 cycle later.
- Unsigned directed sequence (OUT_REG=1, signed_mode=0), with each input held for a cycle with in_valid=1 -> out_valid=1 and results 1001, 0001, 0010 on the following cycles:
  - a=11,b=11 -> 1001
  - a=01,b=01 -> 0001
  - a=10,b=01 -> 0010
- Exhaustive unsigned and signed: all 16 (a,b) pairs in each mode, back-to-back -> every result matches the reference product 1 cycle later. Signed checks include 10*10=0100, 11*11=0001, 10*01=1110.
- Hold: in_valid=0 after a=11,b=10 (result 0110) while the operands change to 01/01 -> result stays 0110, out_valid=0.
- Reset mid-stream: assert rst while in_valid=1 streaming -> the next edge gives result=0000, out_valid=0, and the in-flight product is discarded.
- OUT_REG=0 build: a=11,b=11 unsigned -> result=1001 combinationally within the same timestep, with no clock edge required.
